adc_decimal_formatter: RTL and testbench
========================================

Name: adc_decimal_formatter

Overview:
- Downstream of the ADS1115 driver; replaces the hex-dump UART path with signed decimal text.
- Accepts one 16-bit sample per o_valid pulse and converts it with a sequential binary-to-BCD engine.
- Emits "[-]ddddd\r\n" byte-by-byte into uart_tx over its tx_data/tx_start/tx_busy handshake.
- On a driver error, emits "E\r\n" once per error assertion.

Parameters:
- SIGNED, 1, 1 = treat i_data as two's complement; 0 = unsigned, range 0..65535.
- ERR_CHAR, 8'h45, byte sent for an error frame ("E").

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_data  input  16  ADC sample, sampled only on accept
- i_valid  input  1  single-cycle sample strobe
- i_error  input  1  driver error level
- o_tx_data  output  8  byte to UART, held stable while o_tx_start is high
- o_tx_start  output  1  single-cycle UART start pulse
- i_tx_busy  input  1  UART busy
- o_busy  output  1  frame in progress (accept through LF issue)
- o_dropped  output  1  single-cycle pulse when a sample is rejected

Behaviour:
- Reset: async on rst_n low. All outputs are 0, the FSM goes to IDLE, and err_armed is set to 1. Reset mid-frame aborts the frame; no further bytes are sent after release.
- States: IDLE -> CONV -> SIGN -> DIGITS -> CR -> LF -> IDLE. Error path: IDLE -> ERR -> CR -> LF -> IDLE.
- IDLE priority:
  - If i_error & err_armed: go to ERR and clear err_armed.
  - Else if i_valid: latch i_data, go to CONV, set o_busy.
  - If i_valid arrives in the same cycle as an accepted error, or while o_busy = 1: the sample is discarded and o_dropped pulses.
- err_armed re-arms on any cycle with i_error = 0.
- Sign handling in CONV:
  - If SIGNED and bit 15 = 1: set neg = 1 and take magnitude = (~data + 1) as unsigned 16-bit. 0x8000 gives 32768.
  - Otherwise neg = 0 and magnitude = data.
- CONV: shift-add-3 double dabble, one magnitude bit per cycle, MSB first.
  - 20-bit BCD (5 digits); add-3 on any nibble >= 5 is applied before each shift, in the same cycle.
  - Exactly 16 cycles.
- Latency: i_valid accepted at edge k. Conversion completes at edge k+16. The first o_tx_start is high after edge k+17, provided i_tx_busy is low.
- Byte issue rule, every emitting state:
  - Issue only when i_tx_busy = 0 and o_tx_start = 0. This guard covers the one-cycle lag before uart_tx raises busy.
  - On issue, load o_tx_data, pulse o_tx_start for 1 cycle, then advance.
  - Otherwise hold; i_tx_busy may stall indefinitely with no byte loss.
- SIGN: emits '-' (0x2D) if neg, otherwise skipped with no cycle spent issuing.
- DIGITS: leading-zero suppression from digit 4 down to digit 1; digit 0 is always sent. Magnitude 0 sends "0". Digits are sent as 0x30 + BCD.
- CR: emits 0x0D. LF: emits 0x0A; o_busy clears on the cycle after the LF issue.
- ERR: emits ERR_CHAR, then CR and LF. i_data is ignored.
- Frame bytes are never interleaved: a new accept occurs only from IDLE.

Decomposition:
- Shared package adc_fmt_pkg holds:
  - ASCII constants: CR, LF, MINUS, ZERO, default ERR_CHAR.
  - The FSM state encoding as a localparam enum (3 bits).
  - BCD_DIGITS = 5.
- One sub-module, bin2bcd_seq:
  - Ports: clk, rst_n, start, bin[15:0], done pulse, bcd[19:0].
  - 16-cycle sequential double dabble with a busy flag; the parent is responsible only for sign handling and digit emission.

Test Plan:
- Basic frame: SIGNED=1, i_data=0x1234, i_tx_busy model = 10 cycles per byte. Expect bytes 34 36 36 30 0D 0A ("4660\r\n"); first o_tx_start at k+17.
- Boundary values: 0x8000 -> "-32768\r\n"; 0xFFFF -> "-1\r\n"; 0x7FFF -> "32767\r\n"; 0x0000 -> "0\r\n". With SIGNED=0, 0xFFFF -> "65535\r\n".
- Overrun: second i_valid 5 cycles after the first. Expect an o_dropped pulse; only the first frame is transmitted; o_busy stays high throughout that frame.
- Error: i_error rises in the same cycle as i_valid. Expect "E\r\n" only and an o_dropped pulse. Holding i_error for 10k cycles produces no repeat; dropping and re-raising it produces a second "E\r\n".
- Backpressure: hold i_tx_busy high for 1000 cycles mid-frame. Expect no byte lost or duplicated, o_tx_data stable while o_tx_start is high, and never two o_tx_start pulses on adjacent cycles.
- Reset mid-frame: assert rst_n low after the 2nd byte. Expect immediate outputs 0 and no further o_tx_start. After release, i_data=0x0064 -> "100\r\n".

Source files
------------

// File: rtl/adc_fmt_pkg.sv
// Shared constants, FSM encoding and digit helper for the ADC decimal formatter.
package adc_fmt_pkg;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_MINUS      = 8'h2D;
  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ERR_CHAR_DEFAULT = 8'h45;

  localparam int BCD_DIGITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SIGN   = 3'd2,
    ST_DIGITS = 3'd3,
    ST_CR     = 3'd4,
    ST_LF     = 3'd5,
    ST_ERR    = 3'd6
  } fmt_state_e;

  // Index of the most significant non-zero digit; 0 when the value is 0.
  function automatic logic [2:0] first_digit(input logic [19:0] bcd);
    first_digit = 3'd0;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) first_digit = 3'(i);
    end
  endfunction

endpackage

// File: rtl/adc_decimal_formatter_bin2bcd.sv
// 16-cycle shift-add-3 binary to 5-digit BCD converter, MSB first.
module bin2bcd_seq
  import adc_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [15:0] sh_q;
  logic [19:0] bcd_q;
  logic [19:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // High during the cycle whose closing edge performs the last shift.
  assign done = busy_q && (cnt_q == 4'd15);
  assign bcd  = bcd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      sh_q   <= 16'd0;
      bcd_q  <= 20'd0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= 4'd0;
      sh_q   <= bin;
      bcd_q  <= 20'd0;
    end else if (busy_q) begin
      {bcd_q, sh_q} <= {adj, sh_q} << 1;
      cnt_q         <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_decimal_formatter.sv
// Formats ADC samples as "[-]ddddd\r\n" (or an error frame) byte by byte into a UART.
module adc_decimal_formatter
  import adc_fmt_pkg::*;
#(
  parameter bit         SIGNED   = 1'b1,
  parameter logic [7:0] ERR_CHAR = ERR_CHAR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  input  logic        i_error,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_busy,
  output logic        o_busy,
  output logic        o_dropped
);

  fmt_state_e  state_q;
  logic        neg_q, lead_q, busy_q, start_q, drop_q, err_armed_q;
  logic [2:0]  dig_q;
  logic [7:0]  tx_data_q;

  logic        err_take, accept, can_issue, conv_done;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [2:0]  cur_idx;
  logic [3:0]  cur_digit;

  assign err_take  = (state_q == ST_IDLE) && i_error && err_armed_q;
  assign accept    = (state_q == ST_IDLE) && !err_take && i_valid;
  assign mag       = (SIGNED && i_data[15]) ? (~i_data + 16'd1) : i_data;
  // UART handshake: a byte is issued only when busy is low and no start pulse
  // is in flight, since the UART raises busy one cycle after seeing start.
  assign can_issue = !i_tx_busy && !start_q;
  assign cur_idx   = lead_q ? first_digit(bcd) : dig_q;
  assign cur_digit = bcd[{cur_idx, 2'b00} +: 4];

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      neg_q       <= 1'b0;
      lead_q      <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      drop_q      <= 1'b0;
      err_armed_q <= 1'b1;
      dig_q       <= 3'd0;
      tx_data_q   <= 8'd0;
    end else begin
      start_q <= 1'b0;
      drop_q  <= i_valid && !accept;
      if (!i_error)      err_armed_q <= 1'b1;
      else if (err_take) err_armed_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (err_take) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b1;
          end else if (accept) begin
            state_q <= ST_CONV;
            busy_q  <= 1'b1;
            neg_q   <= SIGNED && i_data[15];
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            state_q <= neg_q ? ST_SIGN : ST_DIGITS;
            lead_q  <= 1'b1;
          end
        end
        ST_SIGN: begin
          if (can_issue) begin
            tx_data_q <= ASCII_MINUS;
            start_q   <= 1'b1;
            state_q   <= ST_DIGITS;
          end
        end
        ST_DIGITS: begin
          if (can_issue) begin
            tx_data_q <= ASCII_ZERO | {4'd0, cur_digit};
            start_q   <= 1'b1;
            lead_q    <= 1'b0;
            if (cur_idx == 3'd0) state_q <= ST_CR;
            else                 dig_q   <= cur_idx - 3'd1;
          end
        end
        ST_ERR: begin
          if (can_issue) begin
            tx_data_q <= ERR_CHAR;
            start_q   <= 1'b1;
            state_q   <= ST_CR;
          end
        end
        ST_CR: begin
          if (can_issue) begin
            tx_data_q <= ASCII_CR;
            start_q   <= 1'b1;
            state_q   <= ST_LF;
          end
        end
        ST_LF: begin
          if (can_issue) begin
            tx_data_q <= ASCII_LF;
            start_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = start_q;
  assign o_busy     = busy_q;
  assign o_dropped  = drop_q;

endmodule

// File: tb/tb_adc_decimal_formatter.sv
// Directed scoreboard bench for adc_decimal_formatter (signed and unsigned instances).
module tb_adc_decimal_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_data = 16'd0;
  logic        i_valid = 1'b0;
  logic        i_error = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, i_tx_busy, o_busy, o_dropped;

  logic [15:0] u_data = 16'd0;
  logic        u_valid = 1'b0;
  logic [7:0]  u_tx_data;
  logic        u_tx_start, u_tx_busy, u_busy, u_dropped;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          busy_u_cnt = 0;
  logic        force_busy = 1'b0;
  logic        prev_start = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_u_q[$];

  adc_decimal_formatter #(.SIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_error(i_error),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
    .o_busy(o_busy), .o_dropped(o_dropped)
  );

  adc_decimal_formatter #(.SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .i_data(u_data), .i_valid(u_valid), .i_error(1'b0),
    .o_tx_data(u_tx_data), .o_tx_start(u_tx_start), .i_tx_busy(u_tx_busy),
    .o_busy(u_busy), .o_dropped(u_dropped)
  );

  // ---------------- clock / reset / UART models ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART busy rises the cycle after start and lasts 10 cycles per byte.
  always @(posedge clk) begin
    if (o_tx_start)        busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (u_tx_start)          busy_u_cnt <= 10;
    else if (busy_u_cnt > 0) busy_u_cnt <= busy_u_cnt - 1;
  end
  assign i_tx_busy = force_busy || (busy_cnt != 0);
  assign u_tx_busy = (busy_u_cnt != 0);

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (o_tx_start) begin
      check("no_adjacent_start", {31'd0, prev_start}, 32'd0);
      check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
    end
    prev_start <= o_tx_start;
  end

  always @(negedge clk) begin
    if (u_tx_start) begin
      check("u_byte_expected", {31'd0, exp_u_q.size() != 0}, 32'd1);
      if (exp_u_q.size() != 0) check("u_tx_byte", {24'd0, u_tx_data}, {24'd0, exp_u_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input string s, input bit to_u);
    for (int i = 0; i < s.len(); i++) begin
      if (to_u) exp_u_q.push_back(s[i]); else exp_q.push_back(s[i]);
    end
    if (to_u) begin exp_u_q.push_back(8'h0D); exp_u_q.push_back(8'h0A); end
    else begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
  endtask

  task automatic send(input logic [15:0] d, input logic err, output logic dropped, output int acc);
    @(negedge clk);
    i_data  = d;
    i_valid = 1'b1;
    if (err) i_error = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    acc     = cyc;
    dropped = o_dropped;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check({name, "_done"}, {31'd0, n < budget}, 32'd1);
  endtask

  task automatic wait_size(input string name, input int sz, input int budget);
    int n = 0;
    while (exp_q.size() > sz && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check({name, "_progress"}, {31'd0, n < budget}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic dropped;
    int   acc, lat, n, gap, sz;

    repeat (3) @(negedge clk);
    #1;
    check("reset_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("reset_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_dropped", {31'd0, o_dropped}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame and first-byte latency
    push_frame("4660", 1'b0);
    send(16'h1234, 1'b0, dropped, acc);
    check("basic_no_drop", {31'd0, dropped}, 32'd0);
    check("basic_busy", {31'd0, o_busy}, 32'd1);
    n = 0;
    while (!o_tx_start && n < 100) begin @(negedge clk); n++; end
    lat = cyc - acc;
    check("first_start_latency", lat, 32'd17);
    wait_done("basic", 400);

    // Signed boundaries
    push_frame("-32768", 1'b0); send(16'h8000, 1'b0, dropped, acc); wait_done("v8000", 400);
    push_frame("-1", 1'b0);     send(16'hFFFF, 1'b0, dropped, acc); wait_done("vffff", 400);
    push_frame("32767", 1'b0);  send(16'h7FFF, 1'b0, dropped, acc); wait_done("v7fff", 400);
    push_frame("0", 1'b0);      send(16'h0000, 1'b0, dropped, acc); wait_done("v0000", 400);

    // Unsigned instance
    push_frame("65535", 1'b1);
    @(negedge clk); u_data = 16'hFFFF; u_valid = 1'b1;
    @(negedge clk); u_valid = 1'b0;
    n = 0;
    while ((exp_u_q.size() != 0 || u_busy) && n < 400) begin @(negedge clk); #1; n++; end
    check("unsigned_done", {31'd0, n < 400}, 32'd1);

    // Overrun: second sample while busy is dropped, busy holds for the whole frame
    push_frame("5", 1'b0);
    send(16'h0005, 1'b0, dropped, acc);
    repeat (4) @(negedge clk);
    send(16'h0007, 1'b0, dropped, acc);
    check("overrun_dropped", {31'd0, dropped}, 32'd1);
    gap = 0; n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      if (!o_busy) gap++;
      @(negedge clk); #1; n++;
    end
    check("overrun_busy_held", gap, 32'd0);
    wait_done("overrun", 400);
    repeat (50) @(negedge clk);

    // Error with simultaneous sample, held high: exactly one frame
    push_frame("E", 1'b0);
    send(16'h1111, 1'b1, dropped, acc);
    check("error_dropped", {31'd0, dropped}, 32'd1);
    wait_done("error1", 400);
    repeat (10000) @(negedge clk);
    check("error_no_repeat", exp_q.size(), 32'd0);
    i_error = 1'b0;
    @(negedge clk);
    push_frame("E", 1'b0);
    i_error = 1'b1;
    @(negedge clk);
    wait_done("error2", 400);
    i_error = 1'b0;
    repeat (5) @(negedge clk);

    // Backpressure mid-frame
    push_frame("32767", 1'b0);
    send(16'h7FFF, 1'b0, dropped, acc);
    wait_size("backpressure", 5, 400);
    sz = exp_q.size();
    force_busy = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    check("backpressure_hold", exp_q.size(), sz);
    force_busy = 1'b0;
    wait_done("backpressure", 400);

    // Reset mid-frame aborts; next frame is clean
    push_frame("4660", 1'b0);
    send(16'h1234, 1'b0, dropped, acc);
    wait_size("reset_frame", 4, 400);
    rst_n = 1'b0;
    #1;
    check("midreset_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("midreset_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("midreset_busy", {31'd0, o_busy}, 32'd0);
    check("midreset_dropped", {31'd0, o_dropped}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    push_frame("100", 1'b0);
    send(16'h0064, 1'b0, dropped, acc);
    wait_done("after_reset", 400);

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("u_queue_empty", exp_u_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
